// File: rtl/fir_mac_scheduler_if.sv
// Stream, coefficient-write and shared-multiplier signals of the folded-FIR
// scheduler. The slave modport is the scheduler's view; the master modport
// is the surrounding system (sample source, sink, coefficient writer and
// the multiplier itself).
interface fir_mac_scheduler_if #(
    parameter int NTAPS  = 16,
    parameter int DATA_W = 16,
    parameter int COEF_W = 15,
    parameter int PROD_W = 31,
    parameter int OUT_W  = 16
);
    localparam int AW = $clog2(NTAPS);

    logic signed [DATA_W-1:0] s_data;
    logic                     s_valid;
    logic                     s_ready;
    logic signed [OUT_W-1:0]  m_data;
    logic                     m_valid;
    logic                     m_ready;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_wdata;
    logic                     coef_ready;
    logic signed [DATA_W-1:0] mul_din0;
    logic signed [COEF_W-1:0] mul_din1;
    logic signed [PROD_W-1:0] mul_dout;
    logic                     busy;

    modport slave (
        input  s_data, s_valid, m_ready, coef_we, coef_addr, coef_wdata, mul_dout,
        output s_ready, m_data, m_valid, coef_ready, mul_din0, mul_din1, busy
    );

    modport master (
        output s_data, s_valid, m_ready, coef_we, coef_addr, coef_wdata, mul_dout,
        input  s_ready, m_data, m_valid, coef_ready, mul_din0, mul_din1, busy
    );
endinterface

// File: rtl/fir_mac_scheduler.sv
// Folded-FIR controller: one external combinational multiplier is time-shared
// over all NTAPS taps, one tap per cycle. Owns the circular sample delay line,
// the coefficient file and the accumulator.
// Optional feature macro: FIR_SCHED_SAT_EN -- when defined the scaled result
// saturates to the OUT_W signed range; otherwise it wraps (two's complement).
module fir_mac_scheduler #(
    parameter int NTAPS  = 16,
    parameter int DATA_W = 16,
    parameter int COEF_W = 15,
    parameter int PROD_W = 31,
    parameter int ACC_W  = 35,
    parameter int SHIFT  = 14,
    parameter int OUT_W  = 16
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    fir_mac_scheduler_if.slave bus
);
    localparam int AW = $clog2(NTAPS);
    localparam logic [AW-1:0] LAST_TAP = AW'(NTAPS - 1);
    localparam logic signed [ACC_W-1:0] ROUND_C = ACC_W'(64'sd1 <<< (SHIFT - 1));
`ifdef FIR_SCHED_SAT_EN
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = ACC_W'(-(64'sd1 <<< (OUT_W - 1)));
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   state_next_s;
    logic [AW-1:0]            wr_ptr_r;
    logic [AW-1:0]            newest_ptr_r;
    logic [AW-1:0]            k_r;
    logic [AW-1:0]            rd_idx_s;
    logic signed [DATA_W-1:0] delay_r [NTAPS];
    logic signed [COEF_W-1:0] coef_r  [NTAPS];
    logic signed [ACC_W-1:0]  acc_r;
    logic signed [ACC_W-1:0]  acc_sum_s;
    logic signed [OUT_W-1:0]  m_data_r;
    logic                     m_valid_r;
    logic                     last_tap_s;

    // Round half-up, arithmetic shift, then saturate or wrap to OUT_W.
    function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] r;
        r = (acc + ROUND_C) >>> SHIFT;
`ifdef FIR_SCHED_SAT_EN
        if (r > OUT_MAX) begin
            return OUT_MAX[OUT_W-1:0];
        end else if (r < OUT_MIN) begin
            return OUT_MIN[OUT_W-1:0];
        end else begin
            return r[OUT_W-1:0];
        end
`else
        return OUT_W'(r);
`endif
    endfunction

    // Tap k reads the sample k steps older than the newest one (circular buffer).
    assign rd_idx_s   = newest_ptr_r - k_r;
    assign last_tap_s = (k_r == LAST_TAP);
    assign acc_sum_s  = acc_r + {{(ACC_W - PROD_W){bus.mul_dout[PROD_W-1]}}, bus.mul_dout};

    assign bus.m_data  = m_data_r;
    assign bus.m_valid = m_valid_r;

    // FSM state register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.s_valid) begin
                    state_next_s = ST_MAC;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (last_tap_s) begin
                    state_next_s = ST_OUT;
                end else begin
                    state_next_s = ST_MAC;
                end
            end
            ST_OUT: begin
                if (bus.m_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_OUT;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM outputs decoded from the registered state only.
    always_comb begin
        bus.s_ready    = 1'b0;
        bus.coef_ready = 1'b0;
        bus.busy       = 1'b0;
        bus.mul_din0   = {DATA_W{1'b0}};
        bus.mul_din1   = {COEF_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                bus.s_ready    = 1'b1;
                bus.coef_ready = 1'b1;
            end
            ST_MAC: begin
                bus.busy     = 1'b1;
                bus.mul_din0 = delay_r[rd_idx_s];
                bus.mul_din1 = coef_r[k_r];
            end
            ST_OUT: begin
                bus.busy = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    // Datapath: delay line, coefficient file, accumulator and output register.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr_r     <= {AW{1'b0}};
            newest_ptr_r <= {AW{1'b0}};
            k_r          <= {AW{1'b0}};
            acc_r        <= {ACC_W{1'b0}};
            m_data_r     <= {OUT_W{1'b0}};
            m_valid_r    <= 1'b0;
            for (int i = 0; i < NTAPS; i++) begin
                delay_r[i] <= {DATA_W{1'b0}};
                coef_r[i]  <= {COEF_W{1'b0}};
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.s_valid) begin
                        delay_r[wr_ptr_r] <= bus.s_data;
                        newest_ptr_r      <= wr_ptr_r;
                        wr_ptr_r          <= wr_ptr_r + AW'(1);
                        acc_r             <= {ACC_W{1'b0}};
                        k_r               <= {AW{1'b0}};
                    end
                    // A write alongside an accepted sample lands before that sample's MAC pass.
                    if (bus.coef_we) begin
                        coef_r[bus.coef_addr] <= bus.coef_wdata;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_sum_s;
                    if (last_tap_s) begin
                        m_data_r  <= scale_out(acc_sum_s);
                        m_valid_r <= 1'b1;
                    end else begin
                        k_r <= k_r + AW'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.m_ready) begin
                        m_valid_r <= 1'b0;
                    end
                end
                default: begin
                    m_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Randomized self-checking bench for fir_mac_scheduler against a direct-form
// FIR reference (shift-register history, dot product, round/shift, sat/wrap).
module tb_fir_mac_scheduler;
    localparam int NTAPS  = 16;
    localparam int DATA_W = 16;
    localparam int COEF_W = 15;
    localparam int PROD_W = 31;
    localparam int ACC_W  = 35;
    localparam int SHIFT  = 14;
    localparam int OUT_W  = 16;
    localparam int AW     = $clog2(NTAPS);

    logic ap_clk = 1'b0;
    logic ap_rst;
    logic signed [31:0] prod_full;

    fir_mac_scheduler_if #(.NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W),
                           .PROD_W(PROD_W), .OUT_W(OUT_W)) bus ();

    fir_mac_scheduler #(.NTAPS(NTAPS), .DATA_W(DATA_W), .COEF_W(COEF_W), .PROD_W(PROD_W),
                        .ACC_W(ACC_W), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus.slave)
    );

    always #5 ap_clk = ~ap_clk;

    // Shared combinational multiplier.
    assign prod_full    = 32'(bus.mul_din0) * 32'(bus.mul_din1);
    assign bus.mul_dout = prod_full[PROD_W-1:0];

    int n_checks = 0;
    int n_fail   = 0;
    longint cyc  = 0;
    longint last_accept = 0;

    // Free-running posedge counter for period measurement.
    always @(posedge ap_clk) cyc <= cyc + 1;

    // Reference model: hist_m[0] is the newest sample.
    int coef_m [NTAPS];
    int hist_m [NTAPS];

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_out();
        longint acc = 0;
        longint r;
        logic [63:0] rb;
        for (int k = 0; k < NTAPS; k++) acc += longint'(hist_m[k]) * longint'(coef_m[k]);
        r = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`ifdef FIR_SCHED_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        return r;
`else
        rb = r;
        return longint'($signed(rb[OUT_W-1:0]));
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) begin
            coef_m[k] = 0;
            hist_m[k] = 0;
        end
    endtask

    task automatic model_push(input int v);
        for (int k = NTAPS - 1; k > 0; k--) hist_m[k] = hist_m[k-1];
        hist_m[0] = v;
    endtask

    // Called at a negedge; waits for IDLE then writes one coefficient.
    task automatic write_coef(input int addr, input int val);
        int n = 0;
        while (!bus.coef_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        check_eq("coef_ready_wait", longint'(bus.coef_ready), 1);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = AW'(addr);
        bus.coef_wdata = COEF_W'(val);
        @(negedge ap_clk);
        bus.coef_we = 1'b0;
        coef_m[addr] = val;
    endtask

    // Called at a negedge; sends one sample, checks the MAC pass and the
    // output, holds m_ready low for 'hold' cycles in OUT, then handshakes.
    task automatic send_sample(input int val, input int hold, output longint got);
        int n = 0;
        while (!bus.s_ready && n < 100) begin
            @(negedge ap_clk);
            n++;
        end
        check_eq("s_ready_wait", longint'(bus.s_ready), 1);
        bus.s_data  = DATA_W'(val);
        bus.s_valid = 1'b1;
        bus.m_ready = (hold == 0);
        @(negedge ap_clk);
        bus.s_valid = 1'b0;
        last_accept = cyc;
        model_push(val);
        n = 1;
        while (!bus.m_valid && n < 60) begin
            if (n <= NTAPS) begin
                check_eq("busy_mac", longint'(bus.busy), 1);
                check_eq("mul_din0", longint'(bus.mul_din0), longint'(hist_m[n-1]));
                check_eq("mul_din1", longint'(bus.mul_din1), longint'(coef_m[n-1]));
            end
            @(negedge ap_clk);
            n++;
        end
        check_eq("latency", n, NTAPS + 1);
        got = longint'(bus.m_data);
        check_eq("m_data", got, model_out());
        for (int i = 0; i < hold; i++) begin
            check_eq("hold_valid", longint'(bus.m_valid), 1);
            check_eq("hold_data", longint'(bus.m_data), got);
            check_eq("hold_s_ready", longint'(bus.s_ready), 0);
            check_eq("hold_coef_ready", longint'(bus.coef_ready), 0);
            bus.coef_we    = 1'b1;
            bus.coef_addr  = AW'($urandom_range(0, NTAPS - 1));
            bus.coef_wdata = COEF_W'($urandom);
            @(negedge ap_clk);
        end
        bus.coef_we = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge ap_clk);
        check_eq("post_hs_valid", longint'(bus.m_valid), 0);
        check_eq("post_hs_s_ready", longint'(bus.s_ready), 1);
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        model_reset();
    endtask

    // Main stimulus sequence.
    initial begin
        longint got;
        longint t0;
        int cnt;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.m_ready = 1'b1;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
        ap_rst = 1'b1;
        model_reset();
        repeat (2) @(posedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;

        check_eq("rst_m_valid", longint'(bus.m_valid), 0);
        check_eq("rst_m_data", longint'(bus.m_data), 0);
        check_eq("rst_s_ready", longint'(bus.s_ready), 1);
        check_eq("rst_coef_ready", longint'(bus.coef_ready), 1);
        check_eq("rst_busy", longint'(bus.busy), 0);
        check_eq("rst_mul_din0", longint'(bus.mul_din0), 0);
        check_eq("rst_mul_din1", longint'(bus.mul_din1), 0);

        // Single tap.
        write_coef(0, 8192);
        send_sample(1000, 0, got);
        check_eq("single_tap", got, 500);

        // Impulse response with wr_ptr wrap; back-to-back period check.
        do_reset();
        for (int k = 0; k < NTAPS; k++) write_coef(k, 512 * (k + 1));
        send_sample(32767, 0, got);
        check_eq("impulse_first", got, 1024);
        t0 = last_accept;
        send_sample(0, 0, got);
        check_eq("period", last_accept - t0, NTAPS + 2);
        for (int i = 0; i < 18; i++) send_sample(0, 0, got);
        check_eq("impulse_tail", got, 0);

        // Overflow, positive then negative coefficients.
        for (int k = 0; k < NTAPS; k++) write_coef(k, 16383);
        for (int i = 0; i < NTAPS; i++) send_sample(32767, 0, got);
`ifdef FIR_SCHED_SAT_EN
        check_eq("ovf_pos", got, 32767);
`else
        check_eq("ovf_pos", got, -48);
`endif
        for (int k = 0; k < NTAPS; k++) write_coef(k, -16384);
        send_sample(32767, 0, got);
`ifdef FIR_SCHED_SAT_EN
        check_eq("ovf_neg", got, -32768);
`else
        check_eq("ovf_neg", got, 16);
`endif

        // Backpressure with dropped writes, then impulse readback of coefficients.
        write_coef(3, 1234);
        send_sample(int'($urandom_range(0, 65535)) - 32768, 10, got);
        for (int i = 0; i < NTAPS - 1; i++) send_sample(0, 0, got);
        for (int i = 0; i < 4; i++) send_sample(20000, 0, got);

        // Randomized traffic with occasional coefficient writes and stalls.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                write_coef(int'($urandom_range(0, NTAPS - 1)),
                           int'($urandom_range(0, 32767)) - 16384);
            send_sample(int'($urandom_range(0, 65535)) - 32768,
                        int'($urandom_range(0, 3)), got);
        end

        // Reset in the middle of the MAC pass (tap k=5).
        bus.s_data  = DATA_W'(12345);
        bus.s_valid = 1'b1;
        @(negedge ap_clk);
        bus.s_valid = 1'b0;
        repeat (5) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        model_reset();
        check_eq("midrst_m_valid", longint'(bus.m_valid), 0);
        check_eq("midrst_s_ready", longint'(bus.s_ready), 1);
        check_eq("midrst_busy", longint'(bus.busy), 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.m_valid) cnt++;
            @(negedge ap_clk);
        end
        check_eq("midrst_no_emit", cnt, 0);
        send_sample(int'($urandom_range(1, 32767)), 0, got);
        check_eq("midrst_cleared", got, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
